// File: rtl/clock_pkg.sv
// clock_pkg: shared state type, digit widths and digit helpers for the clock time-entry logic.
package clock_pkg;

    localparam int TENS_W  = 3;
    localparam int UNITS_W = 4;

    typedef logic [TENS_W-1:0]  tens_t;
    typedef logic [UNITS_W-1:0] units_t;

    typedef enum logic [1:0] {IDLE, SET_TENS, SET_UNITS} set_state_t;

    // Largest legal units digit for a given tens digit: 9 below the top tens value.
    function automatic units_t units_top(input tens_t tens, input int modulo);
        return (int'(tens) < (modulo - 1) / 10) ? units_t'(9) : units_t'((modulo - 1) % 10);
    endfunction

    // tens*10 + units built as (t<<3)+(t<<1)+u; never exceeds 6 bits for legal digits.
    function automatic logic [5:0] times_of(input tens_t t, input units_t u);
        return {t, 3'b000} + {2'b00, t, 1'b0} + {2'b00, u};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: two-flop synchroniser plus delay flop, one-cycle evt on a rising button level.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic evt_o
);

    logic s1_q, s2_q, s3_q;

    // Reset to all ones so a button already held through reset never produces an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1_q, s2_q, s3_q} <= 3'b111;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign evt_o = s2_q & ~s3_q;

endmodule

// File: rtl/time_digit_setter.sv
// time_digit_setter: edits a tens then units digit from buttons and commits tens*10+units
// as a load pulse to a modulo counter.
module time_digit_setter
    import clock_pkg::*;
#(
    parameter int MODULO = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [5:0] cur_times,
    output logic [5:0] times,
    output logic       load,
    output logic       editing,
    output logic       edit_tens,
    output logic       edit_units
);

    localparam tens_t      TMAX = tens_t'((MODULO - 1) / 10);
    localparam logic [5:0] MOD6 = 6'(MODULO);

    logic       mode_evt, inc_evt;
    set_state_t state_q, state_d;
    tens_t      tens_q, tens_d, tens_inc;
    units_t     units_q, units_d, utop;
    logic [5:0] times_q;
    logic       load_q, load_d, editing_q, edit_tens_q, edit_units_q;
    logic       cur_ok;

    btn_sync_edge u_mode (.clk(clk), .rst_n(rst_n), .btn_i(mode_btn), .evt_o(mode_evt));
    btn_sync_edge u_inc  (.clk(clk), .rst_n(rst_n), .btn_i(inc_btn),  .evt_o(inc_evt));

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        units_d  = units_q;
        load_d   = 1'b0;
        cur_ok   = cur_times < MOD6;
        utop     = units_top(tens_q, MODULO);
        tens_inc = (tens_q == TMAX) ? '0 : tens_q + 1'b1;
        // mode has priority over inc in every state, so a coincident inc is dropped.
        case (state_q)
            IDLE: begin
                if (mode_evt) begin
                    state_d = SET_TENS;
                    tens_d  = cur_ok ? tens_t'(cur_times / 6'd10) : '0;
                    units_d = cur_ok ? units_t'(cur_times % 6'd10) : '0;
                end
            end
            SET_TENS: begin
                if (mode_evt) begin
                    state_d = SET_UNITS;
                end else if (inc_evt) begin
                    tens_d  = tens_inc;
                    units_d = (units_q > units_top(tens_inc, MODULO)) ? units_top(tens_inc, MODULO) : units_q;
                end
            end
            SET_UNITS: begin
                if (mode_evt) begin
                    state_d = IDLE;
                    load_d  = 1'b1;
                end else if (inc_evt) begin
                    units_d = (units_q == utop) ? '0 : units_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tens_q       <= '0;
            units_q      <= '0;
            times_q      <= '0;
            load_q       <= 1'b0;
            editing_q    <= 1'b0;
            edit_tens_q  <= 1'b0;
            edit_units_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            times_q      <= times_of(tens_d, units_d);
            load_q       <= load_d;
            editing_q    <= state_d != IDLE;
            edit_tens_q  <= state_d == SET_TENS;
            edit_units_q <= state_d == SET_UNITS;
        end
    end

    assign times      = times_q;
    assign load       = load_q;
    assign editing    = editing_q;
    assign edit_tens  = edit_tens_q;
    assign edit_units = edit_units_q;

endmodule
